hdmi_video_timing_ctrl: RTL

- Raster sequencer for the three-channel TMDS encoder datapath.
- Generates H/V timing and drives VDE, per-channel 8-bit video data and the 2-bit control data, one pixel per clk.
- Pulls pixels from the DDR-backed pixel FIFO over a valid/ready handshake and keeps frame alignment using the FIFO's start-of-frame flag.

---
 rtl/hdmi_pkg.sv | 53 +++++
 rtl/hdmi_raster_counter.sv | 77 +++++++
 rtl/hdmi_video_timing_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI raster sequencer: FSM states, 640x480
// timing defaults, pixel field offsets and colour-bar constants.
package hdmi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FLUSH  = 3'd1,
      ST_ARMED  = 3'd2,
      ST_RUN    = 3'd3,
      ST_RESYNC = 3'd4
   } state_e;

   localparam int CNT_W = 12;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int PIX_R_LSB = 16;
   localparam int PIX_G_LSB = 8;
   localparam int PIX_B_LSB = 0;

   localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
   localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
   localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] BAR_RED     = 24'hFF0000;
   localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
   localparam logic [23:0] BAR_BLACK   = 24'h000000;

   // Colour of bar number idx, left to right across the active line.
   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/hdmi_raster_counter.sv
// Horizontal/vertical raster counter with active, sync and frame-wrap flags.
// Counters park at the origin whenever run is low.
module hdmi_raster_counter
   import hdmi_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic [CNT_W-1:0] hcnt,
   output logic [CNT_W-1:0] vcnt,
   output logic             active,
   output logic             hsync,
   output logic             vsync,
   output logic             frame_end
);

   localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] vcnt_q, vcnt_d;
   logic             line_end;

   // Position flags decoded straight from the current counter values.
   always_comb begin
      line_end  = (hcnt_q == H_LAST);
      frame_end = line_end && (vcnt_q == V_LAST);
      active    = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
      hsync     = (hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E);
      vsync     = (vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E);
   end

   // Next raster position: advance while running, otherwise park at origin.
   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (!run) begin
         hcnt_d = '0;
         vcnt_d = '0;
      end else if (line_end) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
         hcnt_d = hcnt_q + 1'b1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   assign hcnt = hcnt_q;
   assign vcnt = vcnt_q;

endmodule

// File: rtl/hdmi_video_timing_ctrl.sv
// Raster sequencer for the TMDS encoders: pulls pixels from the frame FIFO,
// keeps frame alignment via pix_sof and drives VDE, video and control data.
// Build option: define TEST_PATTERN_EN to show colour bars instead of black
// while the stream is not locked (FLUSH/ARMED/RESYNC).
//
// Pixel handshake: a FIFO word is consumed on a clk edge where pix_valid and
// pix_ready are both high; pix_data/pix_sof must be stable while pix_valid is
// high, and pix_ready is a combinational function of state, raster position
// and the offered word's pix_sof flag.
module hdmi_video_timing_ctrl
   import hdmi_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             pix_valid,
   input  logic [23:0]      pix_data,
   input  logic             pix_sof,
   output logic             pix_ready,
   output logic             vde,
   output logic [7:0]       vd_r,
   output logic [7:0]       vd_g,
   output logic [7:0]       vd_b,
   output logic [1:0]       cd_b,
   output logic [1:0]       cd_g,
   output logic [1:0]       cd_r,
   output logic             frame_start,
   output logic             underflow,
   output logic [CNT_W-1:0] hcnt,
   output logic [CNT_W-1:0] vcnt,
   output state_e           dbg_state
);

   localparam logic [1:0] CD_IDLE = {2{~SYNC_POL}};

   state_e      state_q, state_d;
   logic        underflow_q, underflow_d;
   logic        vde_q, vde_d;
   logic [23:0] vd_q, vd_d;
   logic [1:0]  cd_b_q, cd_b_d;

   logic        active, hsync, vsync, frame_end;
   logic        run_cnt, at_origin, sof_seen, misalign, pix_err;
   logic [23:0] fill_pix;

   assign run_cnt = enable && (state_q != ST_IDLE);

   hdmi_raster_counter #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_raster (
      .clk       (clk),
      .rst       (rst),
      .run       (run_cnt),
      .hcnt      (hcnt),
      .vcnt      (vcnt),
      .active    (active),
      .hsync     (hsync),
      .vsync     (vsync),
      .frame_end (frame_end)
   );

`ifdef TEST_PATTERN_EN
   localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);
   logic [CNT_W-1:0] bar_pos;

   // Colour bar selected by horizontal position within the active line.
   always_comb begin
      bar_pos  = hcnt / BAR_W;
      fill_pix = bar_color(bar_pos[2:0]);
   end
`else
   assign fill_pix = BAR_BLACK;
`endif

   // Pixel qualification: a sof anywhere but the origin means the FIFO and
   // raster disagree about frame boundaries; in RUN that is a stream error.
   always_comb begin
      at_origin = (hcnt == '0) && (vcnt == '0);
      sof_seen  = pix_valid && pix_sof;
      misalign  = sof_seen && !at_origin;
      pix_err   = active && (!pix_valid || misalign);
      pix_ready = ((state_q == ST_FLUSH) && !sof_seen) ||
                  ((state_q == ST_RUN) && active && !misalign);
      frame_start = (state_q != ST_IDLE) && at_origin;
   end

   // Next-state logic for stream alignment and the sticky underflow flag.
   always_comb begin
      state_d     = state_q;
      underflow_d = underflow_q;
      if (!enable) begin
         state_d     = ST_IDLE;
         underflow_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE:   state_d = ST_FLUSH;
            ST_FLUSH:  if (sof_seen) state_d = ST_ARMED;
            ST_ARMED:  if (frame_end) state_d = ST_RUN;
            ST_RUN: begin
               if (pix_err) begin
                  state_d     = ST_RESYNC;
                  underflow_d = 1'b1;
               end
            end
            ST_RESYNC: if (frame_end) state_d = ST_FLUSH;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Encoder-facing outputs for the current raster position.
   always_comb begin
      vde_d  = 1'b0;
      vd_d   = '0;
      cd_b_d = CD_IDLE;
      if (enable && (state_q != ST_IDLE)) begin
         cd_b_d = {vsync ? SYNC_POL : ~SYNC_POL, hsync ? SYNC_POL : ~SYNC_POL};
         if (active) begin
            vde_d = 1'b1;
            if (state_q == ST_RUN) begin
               vd_d = pix_err ? BAR_BLACK : pix_data;
            end else begin
               vd_d = fill_pix;
            end
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         underflow_q <= 1'b0;
         vde_q       <= 1'b0;
         vd_q        <= '0;
         cd_b_q      <= CD_IDLE;
      end else begin
         state_q     <= state_d;
         underflow_q <= underflow_d;
         vde_q       <= vde_d;
         vd_q        <= vd_d;
         cd_b_q      <= cd_b_d;
      end
   end

   assign vde       = vde_q;
   assign vd_r      = vd_q[PIX_R_LSB +: 8];
   assign vd_g      = vd_q[PIX_G_LSB +: 8];
   assign vd_b      = vd_q[PIX_B_LSB +: 8];
   assign cd_b      = cd_b_q;
   assign cd_g      = 2'b00;
   assign cd_r      = 2'b00;
   assign underflow = underflow_q;
   assign dbg_state = state_q;

endmodule
